// File: rtl/dram_pkg.sv
// Command and bank-state encodings shared by the DRAM controller and the device responder.
package dram_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_ACT = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    BANK_CLOSED     = 2'b00,
    BANK_ACTIVATING = 2'b01,
    BANK_OPEN       = 2'b10
  } bank_state_e;

endpackage

// File: rtl/dram_device_responder_if.sv
// Controller <-> device command/data bus; master is the controller, slave is the device model.
interface dram_device_responder_if #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  logic [1:0]                    cmd;
  logic [$clog2(NUM_OF_BANKS)-1:0] cs;
  logic [$clog2(NUM_OF_ROWS)-1:0]  row_addr;
  logic [$clog2(NUM_OF_COLS)-1:0]  col_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [DATA_WIDTH-1:0]         dram_data_out;
  logic                          data_valid;
  logic [NUM_OF_BANKS-1:0]       bank_open;
  logic                          cmd_err;

  modport master (
    output cmd, cs, row_addr, col_addr, wr_data,
    input  dram_data_out, data_valid, bank_open, cmd_err
  );

  modport slave (
    input  cmd, cs, row_addr, col_addr, wr_data,
    output dram_data_out, data_valid, bank_open, cmd_err
  );
endinterface

// File: rtl/dram_device_responder_bank_state.sv
// Per-bank open-row tracker: ACT latches the row and arms tRCD; rw_ok rises T_RCD cycles after the ACT cycle.
module dram_bank_state
  import dram_pkg::*;
#(
  parameter int ROW_W = 7,
  parameter int T_RCD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic [ROW_W-1:0] row_addr,
  output logic             is_open,
  output logic             rw_ok,
  output logic [ROW_W-1:0] open_row
);
  localparam int CNT_W = (T_RCD < 2) ? 1 : $clog2(T_RCD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_RCD - 1);

  bank_state_e      state;
  logic [CNT_W-1:0] trcd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BANK_CLOSED;
      trcd_cnt <= '0;
      open_row <= '0;
      is_open  <= 1'b0;
      rw_ok    <= 1'b0;
    end else if (act) begin
      // Re-ACT on an open/activating bank is an implicit precharge: new row, tRCD restarts.
      open_row <= row_addr;
      is_open  <= 1'b1;
      if (T_RCD <= 1) begin
        state    <= BANK_OPEN;
        rw_ok    <= 1'b1;
        trcd_cnt <= '0;
      end else begin
        state    <= BANK_ACTIVATING;
        rw_ok    <= 1'b0;
        trcd_cnt <= CNT_LOAD;
      end
    end else begin
      case (state)
        BANK_ACTIVATING: begin
          if (trcd_cnt <= CNT_W'(1)) begin
            state    <= BANK_OPEN;
            rw_ok    <= 1'b1;
            trcd_cnt <= '0;
          end else begin
            trcd_cnt <= trcd_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dram_device_responder.sv
// DRAM device model: per-bank ACT/RD/WR decode, storage array, read data CAS_LAT cycles after RD, no backpressure.
// DRAM_RESP_ERR_CHECK_EN adds a registered cmd_err pulse and a saturating err_count for illegal commands.
module dram_device_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int CAS_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_device_responder_if.slave  bus
);
  localparam int ROW_W = $clog2(NUM_OF_ROWS);

  logic                    cs_ok, row_ok, col_ok;
  logic                    act_ok, rd_ok, wr_ok;
  logic [NUM_OF_BANKS-1:0] bank_act, bank_is_open, bank_rw_ok;
  logic [ROW_W-1:0]        open_row [NUM_OF_BANKS];
  logic [ROW_W-1:0]        sel_row;

  always_comb begin
    cs_ok    = int'(bus.cs) < NUM_OF_BANKS;
    row_ok   = int'(bus.row_addr) < NUM_OF_ROWS;
    col_ok   = int'(bus.col_addr) < NUM_OF_COLS;
    sel_row  = open_row[bus.cs];
    act_ok   = cs_ok && row_ok && (bus.cmd == CMD_ACT);
    rd_ok    = cs_ok && col_ok && bank_rw_ok[bus.cs] && (bus.cmd == CMD_RD);
    wr_ok    = cs_ok && col_ok && bank_rw_ok[bus.cs] && (bus.cmd == CMD_WR);
    bank_act = '0;
    if (act_ok) bank_act[bus.cs] = 1'b1;
  end

  for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
    dram_bank_state #(
      .ROW_W (ROW_W),
      .T_RCD (T_RCD)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .act      (bank_act[b]),
      .row_addr (bus.row_addr),
      .is_open  (bank_is_open[b]),
      .rw_ok    (bank_rw_ok[b]),
      .open_row (open_row[b])
    );
  end

  // Storage is deliberately outside the reset domain.
  logic [DATA_WIDTH-1:0] mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.cs][sel_row][bus.col_addr] <= bus.wr_data;
  end

  logic [CAS_LAT-1:0]    pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [CAS_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < CAS_LAT; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_ok;
      pipe_dat[0] <= rd_ok ? mem[bus.cs][sel_row][bus.col_addr] : '0;
      for (int i = 1; i < CAS_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign bus.dram_data_out = pipe_dat[CAS_LAT-1];
  assign bus.data_valid    = pipe_vld[CAS_LAT-1];
  assign bus.bank_open     = bank_is_open;

`ifdef DRAM_RESP_ERR_CHECK_EN
  logic        illegal;
  logic        cmd_err_q;
  logic [15:0] err_count;

  assign illegal = (bus.cmd != CMD_NOP) && !(act_ok || rd_ok || wr_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
      err_count <= '0;
    end else begin
      cmd_err_q <= illegal;
      if (illegal && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  assign bus.cmd_err = cmd_err_q;
`else
  assign bus.cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_device_responder.sv
// Directed vector table, hand-written corner sequences and a random run, all against a cycle-indexed reference model.
module tb_dram_device_responder;
  import dram_pkg::*;

  localparam int DW = 1;
  localparam int NB = 8;
  localparam int NR = 128;
  localparam int NC = 8;
  localparam int TRCD = 2;
  localparam int CL = 2;
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(NR);
  localparam int CW = $clog2(NC);
`ifdef DRAM_RESP_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dram_device_responder_if #(.DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();

  dram_device_responder #(
    .DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(TRCD), .CAS_LAT(CL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: bank = (first ACT cycle, latest ACT cycle, row); expectations indexed by cycle.
  logic [DW-1:0] m_mem   [NB][NR][NC];
  bit            m_known [NB][NR][NC];
  int            m_first_act [NB];
  int            m_act [NB];
  int            m_row [NB];
  bit            q_vld [64];
  logic [DW-1:0] q_dat [64];
  bit            q_known [64];
  bit            q_err [64];
  int            m_err_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] m_open_mask();
    logic [NB-1:0] m = '0;
    for (int b = 0; b < NB; b++)
      if (m_first_act[b] >= 0 && m_first_act[b] < cyc) m[b] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_first_act[b] = -1;
      m_act[b] = -1;
      m_row[b] = 0;
    end
    for (int i = 0; i < 64; i++) begin
      q_vld[i] = 1'b0; q_dat[i] = '0; q_known[i] = 1'b0; q_err[i] = 1'b0;
    end
    m_err_cnt = 0;
  endtask

  task automatic model_apply(input logic [1:0] c, input int b, input int r, input int co, input logic [DW-1:0] wd);
    bit legal = 1'b1;
    int idx;
    if (c == CMD_ACT) begin
      legal = (b < NB) && (r < NR);
      if (legal) begin
        if (m_first_act[b] < 0) m_first_act[b] = cyc;
        m_act[b] = cyc;
        m_row[b] = r;
      end
    end else if (c == CMD_RD || c == CMD_WR) begin
      legal = (b < NB) && (co < NC) && (m_act[b] >= 0) && (cyc >= m_act[b] + TRCD);
      if (legal && c == CMD_WR) begin
        m_mem[b][m_row[b]][co] = wd;
        m_known[b][m_row[b]][co] = 1'b1;
      end else if (legal) begin
        idx = (cyc + CL) % 64;
        q_vld[idx] = 1'b1;
        q_dat[idx] = m_mem[b][m_row[b]][co];
        q_known[idx] = m_known[b][m_row[b]][co];
      end
    end
    if (!legal) begin
      if (ERR_EN) q_err[(cyc + 1) % 64] = 1'b1;
      if (m_err_cnt < 65535) m_err_cnt++;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; outputs sampled on the falling edge.
  task automatic do_cycle(input logic [1:0] c, input int b, input int r, input int co, input logic [DW-1:0] wd,
                          output logic ov, output logic [DW-1:0] od, output logic oe, output logic [NB-1:0] oo);
    int idx;
    bus.cmd = c; bus.cs = BW'(b); bus.row_addr = RW'(r); bus.col_addr = CW'(co); bus.wr_data = wd;
    @(negedge clk);
    ov = bus.data_valid; od = bus.dram_data_out; oe = bus.cmd_err; oo = bus.bank_open;
    idx = cyc % 64;
    chk("data_valid", 32'(ov), 32'(q_vld[idx]));
    if (q_vld[idx]) begin
      if (q_known[idx]) chk("read_data", 32'(od), 32'(q_dat[idx]));
    end else begin
      chk("idle_data_zero", 32'(od), 32'(0));
    end
    chk("bank_open", 32'(oo), 32'(m_open_mask()));
    chk("cmd_err", 32'(oe), 32'(q_err[idx]));
    q_vld[idx] = 1'b0; q_known[idx] = 1'b0; q_err[idx] = 1'b0;
    model_apply(c, b, r, co, wd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.cmd = CMD_NOP;
    rst = 1'b1;
    #1;
    chk("rst_data_valid", 32'(bus.data_valid), 32'(0));
    chk("rst_data_out", 32'(bus.dram_data_out), 32'(0));
    chk("rst_bank_open", 32'(bus.bank_open), 32'(0));
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc += 3;
  endtask

  typedef struct {
    logic [1:0]    cmd;
    int            cs, row, col;
    logic [DW-1:0] wd;
    logic          vld;
    logic [DW-1:0] dat;
    logic          err;
    logic [NB-1:0] open;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] c, input int b, input int r, input int co, input logic wd,
                              input logic v, input logic d, input logic e, input logic [NB-1:0] o);
    vec_t t;
    t.cmd = c; t.cs = b; t.row = r; t.col = co; t.wd = wd;
    t.vld = v; t.dat = d; t.err = e; t.open = o;
    return t;
  endfunction

  vec_t tbl [27];

  initial begin
    logic ov, oe;
    logic [DW-1:0] od;
    logic [NB-1:0] oo;
    logic [DW-1:0] pat [4];

    //            cmd      cs row col wd    vld   dat   err   bank_open
    tbl[0]  = mk(CMD_ACT, 3, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[1]  = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08);
    tbl[2]  = mk(CMD_WR,  3, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08);
    tbl[3]  = mk(CMD_RD,  3, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08);
    tbl[4]  = mk(CMD_ACT, 0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08);
    tbl[5]  = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h09);
    tbl[6]  = mk(CMD_WR,  0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[7]  = mk(CMD_RD,  1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[8]  = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
    tbl[9]  = mk(CMD_ACT, 0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[10] = mk(CMD_RD,  0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[11] = mk(CMD_RD,  0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
    tbl[12] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[13] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h09);
    tbl[14] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[15] = mk(CMD_ACT, 2, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09);
    tbl[16] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[17] = mk(CMD_WR,  2, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[18] = mk(CMD_ACT, 2, 9, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[19] = mk(CMD_WR,  2, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[20] = mk(CMD_WR,  2, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D);
    tbl[21] = mk(CMD_RD,  2, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[22] = mk(CMD_ACT, 2, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[23] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D);
    tbl[24] = mk(CMD_RD,  2, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[25] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    tbl[26] = mk(CMD_NOP, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0D);

    bus.cmd = CMD_NOP; bus.cs = '0; bus.row_addr = '0; bus.col_addr = '0; bus.wr_data = '0;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 27; i++) begin
      do_cycle(tbl[i].cmd, tbl[i].cs, tbl[i].row, tbl[i].col, tbl[i].wd, ov, od, oe, oo);
      chk($sformatf("tbl%0d_vld", i), 32'(ov), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), 32'(od), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d_err", i), 32'(oe), 32'(ERR_EN ? tbl[i].err : 1'b0));
      chk($sformatf("tbl%0d_open", i), 32'(oo), 32'(tbl[i].open));
    end

    // Back-to-back reads, reset lands while the third result is on the bus.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    do_cycle(CMD_ACT, 5, 3, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_NOP, 0, 0, 0, 1'b0, ov, od, oe, oo);
    for (int c = 0; c < 4; c++) do_cycle(CMD_WR, 5, 0, c, pat[c], ov, od, oe, oo);
    for (int c = 0; c < 4; c++) begin
      do_cycle(CMD_RD, 5, 0, c, 1'b0, ov, od, oe, oo);
      if (c >= 2) begin
        chk($sformatf("b2b_vld%0d", c - 2), 32'(ov), 32'(1));
        chk($sformatf("b2b_dat%0d", c - 2), 32'(od), 32'(pat[c-2]));
      end
    end
    bus.cmd = CMD_NOP;
    #2;
    chk("b2b_third_vld", 32'(bus.data_valid), 32'(1));
    chk("b2b_third_dat", 32'(bus.dram_data_out), 32'(pat[2]));
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(CMD_NOP, 0, 0, 0, 1'b0, ov, od, oe, oo);

    // Banks 0 and 7 interleaved; each keeps its own data.
    do_cycle(CMD_ACT, 0, 1, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_ACT, 7, 1, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_WR,  0, 0, 0, 1'b1, ov, od, oe, oo);
    do_cycle(CMD_WR,  7, 0, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_RD,  0, 0, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_RD,  7, 0, 0, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_WR,  0, 0, 3, 1'b0, ov, od, oe, oo);
    chk("ilv_bank0_dat", 32'(od), 32'(1));
    do_cycle(CMD_WR,  7, 0, 3, 1'b1, ov, od, oe, oo);
    chk("ilv_bank7_dat", 32'(od), 32'(0));
    do_cycle(CMD_RD,  7, 0, 3, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_RD,  0, 0, 3, 1'b0, ov, od, oe, oo);
    do_cycle(CMD_NOP, 0, 0, 0, 1'b0, ov, od, oe, oo);
    chk("ilv_bank7_c3", 32'(od), 32'(1));
    do_cycle(CMD_NOP, 0, 0, 0, 1'b0, ov, od, oe, oo);
    chk("ilv_bank0_c3", 32'(od), 32'(0));
    chk("ilv_bank_open", 32'(oo), 32'(8'h81));

    // Random traffic over a small row set so re-opens and re-reads are frequent.
    for (int i = 0; i < 800; i++) begin
      do_cycle(2'($urandom_range(0, 3)), int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, NC - 1)), DW'($urandom), ov, od, oe, oo);
    end
    for (int i = 0; i < 4; i++) do_cycle(CMD_NOP, 0, 0, 0, 1'b0, ov, od, oe, oo);

`ifdef DRAM_RESP_ERR_CHECK_EN
    chk("err_count", 32'(dut.err_count), 32'(m_err_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
